// File: rtl/guess_game_core.sv
// rtl/guess_game_core.sv - parametrised number-guessing game engine
// Digit entry, magnitude hint, guess budget, round timer and multi-round progression.
module guess_game_core #(
  parameter  int N_DIGITS    = 3,
  parameter  int NUM_ROUNDS  = 3,
  parameter  int MAX_GUESSES = 5,
  parameter  int TIME_LIMIT  = 60,
  localparam int AW = $clog2(N_DIGITS + 1),
  localparam int TW = $clog2(TIME_LIMIT + 1),
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_DIGITS-1:0]   digit_inc,
  input  logic                  confirm,
  input  logic                  tick,
  input  logic [4*N_DIGITS-1:0] target,
  output logic [4*N_DIGITS-1:0] guess,
  output logic [AW-1:0]         active_digits,
  output logic [1:0]            hint,
  output logic [3:0]            guesses_left,
  output logic [TW-1:0]         time_left,
  output logic [RW-1:0]         round,
  output logic [2:0]            state_o,
  output logic                  win,
  output logic                  lose
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_CHECK     = 3'd2,
    S_ROUND_WIN = 3'd3,
    S_WIN       = 3'd4,
    S_LOSE      = 3'd5
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [4*N_DIGITS-1:0] r_guess, w_guess_nxt, w_guess_inc;
  logic [1:0]            r_hint, w_hint_nxt;
  logic [RW-1:0]         r_round, w_round_nxt;
  logic [AW-1:0]         r_active, w_active_nxt;
  logic [3:0]            r_gl, w_gl_nxt, w_gl_dec;
  logic [TW-1:0]         r_time, w_time_nxt, w_time_dec;
  logic                  r_win, r_lose, w_win_nxt, w_lose_nxt;
  logic [4*N_DIGITS-1:0] w_mask, w_g, w_t;
  logic                  w_eq, w_low, w_last_round;

  // Inactive digit positions are masked so the compare sees only the digits in play.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (i < int'(r_active)) w_mask[4*i +: 4] = 4'hF;
  end

  assign w_g          = r_guess & w_mask;
  assign w_t          = target & w_mask;
  assign w_eq         = (w_g == w_t);
  assign w_low        = (w_g < w_t);
  assign w_last_round = (r_round == RW'(NUM_ROUNDS - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_guess_nxt  = r_guess;
    w_hint_nxt   = r_hint;
    w_round_nxt  = r_round;
    w_active_nxt = r_active;
    w_gl_nxt     = r_gl;
    w_time_nxt   = r_time;
    w_time_dec   = (tick && r_time != '0) ? r_time - TW'(1) : r_time;
    w_gl_dec     = (r_gl != 4'd0) ? r_gl - 4'd1 : r_gl;
    w_guess_inc  = r_guess;
    for (int i = 0; i < N_DIGITS; i++)
      if (digit_inc[i] && i < int'(r_active))
        w_guess_inc[4*i +: 4] = (r_guess[4*i +: 4] >= 4'd9) ? 4'd0 : r_guess[4*i +: 4] + 4'd1;

    case (r_state)
      S_IDLE: if (confirm) w_state_nxt = S_PLAY;
      S_PLAY: begin
        w_time_nxt = w_time_dec;
        if (tick && w_time_dec == '0) w_state_nxt = S_LOSE;
        else if (confirm)             w_state_nxt = S_CHECK;
        else                          w_guess_nxt = w_guess_inc;
      end
      S_CHECK: begin
        w_time_nxt = w_time_dec;
        w_hint_nxt = w_eq ? 2'b11 : (w_low ? 2'b01 : 2'b10);
        if (w_eq) begin
          w_state_nxt = w_last_round ? S_WIN : S_ROUND_WIN;
        end else begin
          w_gl_nxt = w_gl_dec;
          if (w_gl_dec == 4'd0 || (tick && w_time_dec == '0)) w_state_nxt = S_LOSE;
          else                                                 w_state_nxt = S_PLAY;
        end
      end
      S_ROUND_WIN: if (confirm) begin
        w_state_nxt  = S_PLAY;
        w_round_nxt  = r_round + RW'(1);
        w_active_nxt = (int'(r_round) + 2 >= N_DIGITS) ? AW'(N_DIGITS) : AW'(int'(r_round) + 2);
        w_guess_nxt  = '0;
        w_hint_nxt   = 2'b00;
        w_gl_nxt     = 4'(MAX_GUESSES);
        w_time_nxt   = TW'(TIME_LIMIT);
      end
      S_WIN, S_LOSE: if (confirm) begin
        w_state_nxt  = S_IDLE;
        w_round_nxt  = '0;
        w_active_nxt = AW'(1);
        w_guess_nxt  = '0;
        w_hint_nxt   = 2'b00;
        w_gl_nxt     = 4'(MAX_GUESSES);
        w_time_nxt   = TW'(TIME_LIMIT);
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_win_nxt  = (w_state_nxt == S_WIN);
    w_lose_nxt = (w_state_nxt == S_LOSE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_guess  <= '0;
      r_hint   <= 2'b00;
      r_round  <= '0;
      r_active <= AW'(1);
      r_gl     <= 4'(MAX_GUESSES);
      r_time   <= TW'(TIME_LIMIT);
      r_win    <= 1'b0;
      r_lose   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_guess  <= w_guess_nxt;
      r_hint   <= w_hint_nxt;
      r_round  <= w_round_nxt;
      r_active <= w_active_nxt;
      r_gl     <= w_gl_nxt;
      r_time   <= w_time_nxt;
      r_win    <= w_win_nxt;
      r_lose   <= w_lose_nxt;
    end
  end

  assign guess         = r_guess;
  assign active_digits = r_active;
  assign hint          = r_hint;
  assign guesses_left  = r_gl;
  assign time_left     = r_time;
  assign round         = r_round;
  assign state_o       = r_state;
  assign win           = r_win;
  assign lose          = r_lose;

endmodule

// File: doc/guess_game_core.md
Name: guess_game_core

Overview:
Parametrised game engine for the number-guessing design. It replaces the fixed three-digit flow spread across the input-control, hint and FSM blocks with one core that handles the following for any digit count:
- digit entry
- guess comparison and low/high hint
- guess budget
- countdown timer
- multi-round progression
It sits between the synchronised button pulses and the 7-segment/LED display logic. It takes target digits from the target-number generator.

Parameters:
N_DIGITS, 3, maximum number of BCD guess digits (1..8)
NUM_ROUNDS, 3, rounds per game; round r uses min(r+1, N_DIGITS) active digits
MAX_GUESSES, 5, wrong guesses allowed per round (1..15)
TIME_LIMIT, 60, timer ticks per round (1..127)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
digit_inc  in  N_DIGITS  one-cycle synchronised pulses; bit i increments guess digit i (digit 0 = least significant)
confirm  in  1  one-cycle synchronised confirm pulse
tick  in  1  one-cycle timer enable (1 Hz strobe from the clock divider)
target  in  4*N_DIGITS  target BCD digits, digit i at [4i+3:4i]; stable while in PLAY
guess  out  4*N_DIGITS  current guess digits, same packing
active_digits  out  clog2(N_DIGITS+1)  digits in play this round
hint  out  2  00 none, 01 guess low, 10 guess high, 11 equal
guesses_left  out  4  remaining wrong guesses
time_left  out  clog2(TIME_LIMIT+1)  remaining ticks
round  out  clog2(NUM_ROUNDS)  current round, 0-based
state_o  out  3  IDLE=0, PLAY=1, CHECK=2, ROUND_WIN=3, WIN=4, LOSE=5
win, lose  out  1  level flags, high in WIN / LOSE respectively

Behaviour:
- Reset (rst low, async):
  - state IDLE; guess=0; hint=00; round=0; active_digits=1
  - guesses_left=MAX_GUESSES; time_left=TIME_LIMIT; win=lose=0
  - Release is synchronous to clk and is handled upstream.
- IDLE:
  - digit_inc and tick are ignored.
  - confirm -> PLAY next cycle.
- PLAY:
  - digit_inc[i] with i<active_digits increments digit i mod 10 (9->0). Bits i>=active_digits are ignored and those digits stay 0.
  - Multiple digit_inc bits in one cycle each apply.
  - tick decrements time_left. When time_left reaches 0, go to LOSE next cycle.
  - confirm -> CHECK. Any digit_inc in the same cycle is discarded; the guess is frozen.
  - Simultaneous confirm and final tick: LOSE takes priority.
- CHECK (exactly 1 cycle):
  - Compare active digits as a decimal magnitude, MS active digit first; raw 4-bit compare.
  - hint is registered this cycle and valid from the next cycle.
  - Equal and round<NUM_ROUNDS-1 -> ROUND_WIN.
  - Equal and last round -> WIN.
  - Unequal -> guesses_left decrements. If it reaches 0 -> LOSE, else -> PLAY.
  - A tick in CHECK still decrements time_left. If that empties the timer and the guess is unequal -> LOSE; if equal, the win path takes priority.
- ROUND_WIN:
  - hint holds 11.
  - On confirm:
    - round increments and active_digits=min(round+2, N_DIGITS)
    - guess clears to 0; hint=00
    - guesses_left=MAX_GUESSES; time_left=TIME_LIMIT
    - go to PLAY
  - tick and digit_inc are ignored.
- WIN / LOSE:
  - Terminal. All counters and the guess are frozen and the win/lose flag is held.
  - confirm -> IDLE with all registers restored to reset values.
- All outputs are registered; no combinational input-to-output paths.
- Counters saturate at 0 and never wrap.
- Reset asserted mid-round returns to IDLE immediately, whatever the state.

Test Plan:
1. Reset, then confirm -> state 1, active_digits=1, guesses_left=5, time_left=60. Pulse digit_inc[0] 12 times -> guess digit0=2.
2. Round 0, target=7, guess=3, confirm -> CHECK for one cycle, then hint=01, guesses_left=4, state PLAY. Set guess=9, confirm -> hint=10.
3. Round 0, guess=7 equals target -> ROUND_WIN, hint=11. Confirm -> round=1, active_digits=2, guess=00, guesses_left=5, time_left=60.
4. Five wrong guesses in one round -> after the fifth CHECK, guesses_left=0, state LOSE, lose=1. Confirm -> IDLE, all reset values.
5. In PLAY, 60 ticks with no confirm -> time_left=0, then LOSE. Tick and correct confirm in the same cycle at time_left=1 -> LOSE.
6. Round 2, target=4-5-6, guess=456, confirm -> WIN, win=1. Further digit_inc/tick leave guess and time_left unchanged. Assert rst mid-PLAY -> IDLE asynchronously.
